// File: rtl/pipelined_twos_complement_addsub_pkg.sv
// Shared helpers for the pipelined add/sub: configuration legality and slice width.
package pipelined_twos_complement_addsub_pkg;

  // The word must split into STAGES equal, non-empty slices.
  function automatic bit legal_config(int width, int stages);
    return (width >= 2) && (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

  // Bits resolved per pipeline stage; falls back to the full width for a bad stage count
  // so that elaboration reaches the explicit configuration error.
  function automatic int chunk_width(int width, int stages);
    return (stages >= 1) ? (width / stages) : width;
  endfunction

endpackage

// File: rtl/pipelined_twos_complement_addsub_if.sv
// Valid/ready operand and result bus of the pipelined two's-complement add/sub.
interface pipelined_twos_complement_addsub_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             sub;
  logic             sat;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             c_out;
  logic             overflow;

  // Producer of operands and consumer of results.
  modport master (
    output in_valid, a, b, c_in, sub, sat, out_ready,
    input  in_ready, out_valid, s, c_out, overflow
  );

  // The arithmetic block itself.
  modport slave (
    input  in_valid, a, b, c_in, sub, sat, out_ready,
    output in_ready, out_valid, s, c_out, overflow
  );
endinterface

// File: rtl/pipelined_twos_complement_addsub_chunk_rca.sv
// Combinational CHUNK-bit ripple-carry slice; also exposes the carry into its MSB
// so the top slice can derive signed overflow.
module chunk_rca #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             c_in,
  output logic [CHUNK-1:0] s,
  output logic             c_out,
  output logic             c_msb_in
);
  logic [CHUNK:0] c;

  assign c[0] = c_in;

  for (genvar gi = 0; gi < CHUNK; gi++) begin : g_bit
    assign s[gi]   = a[gi] ^ b[gi] ^ c[gi];
    assign c[gi+1] = (a[gi] & b[gi]) | (c[gi] & (a[gi] ^ b[gi]));
  end

  assign c_out    = c[CHUNK];
  assign c_msb_in = c[CHUNK-1];
endmodule

// File: rtl/pipelined_twos_complement_addsub.sv
// Pipelined two's-complement adder/subtractor: one CHUNK-bit slice per stage, carry
// registered between stages, optional saturation, valid/ready on both sides.
module pipelined_twos_complement_addsub
  import pipelined_twos_complement_addsub_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input logic                               clk,
  input logic                               rst_n,
  pipelined_twos_complement_addsub_if.slave bus
);
  localparam int CHUNK = chunk_width(WIDTH, STAGES);
  localparam int NST   = (STAGES < 1) ? 1 : STAGES;

  if (!legal_config(WIDTH, STAGES)) begin : g_bad_cfg
    $error("pipelined_twos_complement_addsub: WIDTH=%0d STAGES=%0d is not a legal split", WIDTH, STAGES);
  end

  // Stage k inputs. word_in holds finished sum bits below k*CHUNK and still-unprocessed
  // bits of a from k*CHUNK upward, so the sum slice simply overwrites the a slice in place.
  logic [WIDTH-1:0] word_in  [NST];
  logic [WIDTH-1:0] beff_in  [NST];
  logic             carry_in [NST];
  logic             valid_in [NST];
  logic             sat_in   [NST];

  logic             adv;
  logic             out_valid_q;
  logic [WIDTH-1:0] s_q;
  logic             c_out_q;
  logic             overflow_q;

  // Whole pipe moves together whenever the output slot is free or being drained.
  assign adv          = bus.out_ready | ~out_valid_q;
  assign bus.in_ready = adv;

  // Subtraction folds into addition: a + ~b + 1, with the borrow-in cancelling the +1.
  assign word_in[0]  = bus.a;
  assign beff_in[0]  = bus.sub ? ~bus.b : bus.b;
  assign carry_in[0] = bus.c_in ^ bus.sub;
  assign valid_in[0] = bus.in_valid;
  assign sat_in[0]   = bus.sat;

  for (genvar gi = 0; gi < NST; gi++) begin : g_stage
    logic [CHUNK-1:0] slice_s;
    logic             slice_c;
    logic             slice_cmsb;
    logic [WIDTH-1:0] word_d;

    chunk_rca #(.CHUNK(CHUNK)) u_rca (
      .a        (word_in[gi][gi*CHUNK +: CHUNK]),
      .b        (beff_in[gi][gi*CHUNK +: CHUNK]),
      .c_in     (carry_in[gi]),
      .s        (slice_s),
      .c_out    (slice_c),
      .c_msb_in (slice_cmsb)
    );

    // Merge this stage's sum slice into the travelling word.
    always_comb begin
      word_d                        = word_in[gi];
      word_d[gi*CHUNK +: CHUNK]     = slice_s;
    end

    if (gi < NST - 1) begin : g_mid
      logic [WIDTH-1:0] word_q;
      logic [WIDTH-1:0] beff_q;
      logic             carry_q;
      logic             valid_q;
      logic             sat_q;

      // Hand the partial sum, slice carry and skewed upper operands to the next stage.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          word_q  <= '0;
          beff_q  <= '0;
          carry_q <= 1'b0;
          valid_q <= 1'b0;
          sat_q   <= 1'b0;
        end else if (adv) begin
          word_q  <= word_d;
          beff_q  <= beff_in[gi];
          carry_q <= slice_c;
          valid_q <= valid_in[gi];
          sat_q   <= sat_in[gi];
        end
      end

      assign word_in[gi+1]  = word_q;
      assign beff_in[gi+1]  = beff_q;
      assign carry_in[gi+1] = carry_q;
      assign valid_in[gi+1] = valid_q;
      assign sat_in[gi+1]   = sat_q;
    end else begin : g_last
      logic             ovf_d;
      logic             a_msb;
      logic [WIDTH-1:0] s_d;

      // Top slice still carries a's sign bit; it selects the clamp direction.
      assign ovf_d = slice_cmsb ^ slice_c;
      assign a_msb = word_in[gi][WIDTH-1];
      assign s_d   = (sat_in[gi] & ovf_d) ? {a_msb, {(WIDTH-1){~a_msb}}} : word_d;

      // Output register: result and raw flags, held while downstream stalls.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          out_valid_q <= 1'b0;
          s_q         <= '0;
          c_out_q     <= 1'b0;
          overflow_q  <= 1'b0;
        end else if (adv) begin
          out_valid_q <= valid_in[gi];
          s_q         <= s_d;
          c_out_q     <= slice_c;
          overflow_q  <= ovf_d;
        end
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.s         = s_q;
  assign bus.c_out     = c_out_q;
  assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_pipelined_twos_complement_addsub.sv
// Scoreboard bench: a 16-bit/4-stage instance for directed, streaming, backpressure,
// random and reset cases, plus exhaustive 6-bit instances at 1, 2 and 3 stages.
module tb_pipelined_twos_complement_addsub;
  typedef struct {
    logic [15:0] s;
    logic        co;
    logic        ov;
    int          t;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   lat_check = 1'b0;
  bit   start6 = 1'b0;
  bit   rnd_rdy = 1'b0;
  logic rdy16 = 1'b1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, int tag, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s [cfg %0d] at cycle %0d: got 0x%0h, expected 0x%0h", name, tag, cyc, act, req);
    end
  endtask

  // Reference: true signed and unsigned results computed with wide integers.
  function automatic exp_t ref_model(int w, logic [15:0] a, logic [15:0] b, logic ci, logic sub, logic sat);
    exp_t   e;
    longint span, half, ua, ub, sa, sb, cl, tr, ur;
    span = longint'(1) << w;
    half = span / 2;
    ua   = longint'(a) & (span - 1);
    ub   = longint'(b) & (span - 1);
    sa   = (ua >= half) ? ua - span : ua;
    sb   = (ub >= half) ? ub - span : ub;
    cl   = ci ? 64'sd1 : 64'sd0;
    tr   = sub ? (sa - sb - cl) : (sa + sb + cl);
    ur   = sub ? (ua - ub - cl) : (ua + ub + cl);
    e.co = sub ? (ur >= 0) : (ur >= span);
    e.ov = (tr >= half) || (tr < -half);
    if (sat && e.ov) tr = (tr > 0) ? (half - 1) : -half;
    e.s  = 16'(tr & (span - 1));
    e.t  = 0;
    return e;
  endfunction

  // ---------------- 16-bit, 4-stage instance ----------------
  pipelined_twos_complement_addsub_if #(.WIDTH(16)) bus16 ();
  pipelined_twos_complement_addsub #(.WIDTH(16), .STAGES(4)) dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus16.slave)
  );
  exp_t q16[$];

  task automatic drive16(input logic [15:0] a, input logic [15:0] b, input logic ci,
                         input logic sub, input logic sat, output int tries);
    exp_t e;
    bit   done;
    done  = 1'b0;
    tries = 0;
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge clk);
      bus16.in_valid  = 1'b1;
      bus16.a         = a;
      bus16.b         = b;
      bus16.c_in      = ci;
      bus16.sub       = sub;
      bus16.sat       = sat;
      bus16.out_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : rdy16;
      tries++;
      #1;
      if (bus16.in_ready) begin
        e   = ref_model(16, a, b, ci, sub, sat);
        e.t = cyc;
        q16.push_back(e);
        done = 1'b1;
      end
    end
    check("dut16 input accepted", 16, 32'(done), 32'd1);
  endtask

  task automatic tick16(int n);
    repeat (n) begin
      @(negedge clk);
      bus16.in_valid  = 1'b0;
      bus16.out_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : rdy16;
    end
  endtask

  task automatic wait_drain16();
    for (int k = 0; k < 60 && q16.size() != 0; k++) tick16(1);
    check("dut16 drained", 16, 32'(q16.size()), 32'd0);
  endtask

  // Monitor: compares every output transfer against the head of the queue.
  always begin
    exp_t e;
    @(negedge clk);
    #2;
    if (rst_n && bus16.out_valid && bus16.out_ready) begin
      check("dut16 output expected", 16, 32'(q16.size() != 0), 32'd1);
      if (q16.size() != 0) begin
        e = q16.pop_front();
        $display("w16 txn cycle %0d: s=0x%04h c_out=%b overflow=%b (exp 0x%04h %b %b)",
                 cyc, bus16.s, bus16.c_out, bus16.overflow, e.s, e.co, e.ov);
        check("dut16 s", 16, 32'(bus16.s), 32'(e.s));
        check("dut16 c_out", 16, 32'(bus16.c_out), 32'(e.co));
        check("dut16 overflow", 16, 32'(bus16.overflow), 32'(e.ov));
        if (lat_check) check("dut16 latency", 16, cyc - e.t, 32'd4);
      end
    end
  end

  // ---------------- 6-bit instances, STAGES = 1..3, exhaustive ----------------
  for (genvar gi = 0; gi < 3; gi++) begin : g6
    localparam int ST = gi + 1;
    pipelined_twos_complement_addsub_if #(.WIDTH(6)) bus ();
    pipelined_twos_complement_addsub #(.WIDTH(6), .STAGES(ST)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
    );
    exp_t q[$];
    bit   done = 1'b0;

    initial begin
      exp_t        e;
      logic [14:0] vv;
      bus.in_valid  = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.c_in      = 1'b0;
      bus.sub       = 1'b0;
      bus.sat       = 1'b0;
      bus.out_ready = 1'b1;
      wait (start6);
      for (int v = 0; v < 32768; v++) begin
        vv = 15'(v);
        @(negedge clk);
        bus.a        = vv[5:0];
        bus.b        = vv[11:6];
        bus.c_in     = vv[12];
        bus.sub      = vv[13];
        bus.sat      = vv[14];
        bus.in_valid = 1'b1;
        #1;
        check("w6 in_ready", ST, 32'(bus.in_ready), 32'd1);
        if (bus.in_ready) begin
          e   = ref_model(6, {10'b0, vv[5:0]}, {10'b0, vv[11:6]}, vv[12], vv[13], vv[14]);
          e.t = cyc;
          q.push_back(e);
        end
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      for (int k = 0; k < 60 && q.size() != 0; k++) @(negedge clk);
      check("w6 drained", ST, 32'(q.size()), 32'd0);
      done = 1'b1;
    end

    always begin
      exp_t e;
      @(negedge clk);
      #2;
      if (rst_n && bus.out_valid && bus.out_ready) begin
        check("w6 output expected", ST, 32'(q.size() != 0), 32'd1);
        if (q.size() != 0) begin
          e = q.pop_front();
          check("w6 s", ST, 32'(bus.s), 32'(e.s[5:0]));
          check("w6 c_out", ST, 32'(bus.c_out), 32'(e.co));
          check("w6 overflow", ST, 32'(bus.overflow), 32'(e.ov));
          check("w6 latency", ST, cyc - e.t, 32'(ST));
        end
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    int          tries;
    logic [15:0] ra, rb;
    bus16.in_valid  = 1'b0;
    bus16.a         = '0;
    bus16.b         = '0;
    bus16.c_in      = 1'b0;
    bus16.sub       = 1'b0;
    bus16.sat       = 1'b0;
    bus16.out_ready = 1'b1;

    #2 rst_n = 1'b0;
    #20;
    check("reset out_valid", 16, 32'(bus16.out_valid), 32'd0);
    check("reset s", 16, 32'(bus16.s), 32'd0);
    check("reset c_out", 16, 32'(bus16.c_out), 32'd0);
    check("reset overflow", 16, 32'(bus16.overflow), 32'd0);
    check("reset in_ready", 16, 32'(bus16.in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed overflow, saturation and carry-ripple cases.
    lat_check = 1'b1;
    drive16(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, tries);
    drive16(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, tries);
    drive16(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1, tries);
    drive16(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b0, tries);
    drive16(16'h0FFF, 16'h0001, 1'b0, 1'b0, 1'b0, tries);
    drive16(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, tries);
    drive16(16'h0005, 16'h0003, 1'b1, 1'b1, 1'b0, tries);
    tick16(1);
    wait_drain16();

    // Streaming: eight back-to-back, each accepted on its first cycle.
    for (int i = 0; i < 8; i++) begin
      drive16(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), tries);
      check("stream accept first try", 16, tries, 32'd1);
    end
    tick16(1);
    wait_drain16();
    lat_check = 1'b0;

    // Backpressure: fill with out_ready low, stall three cycles with an input pending.
    rdy16 = 1'b0;
    for (int i = 0; i < 3; i++)
      drive16(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), tries);
    for (int k = 0; k < 20 && !bus16.out_valid; k++) begin
      tick16(1);
      #2;
    end
    check("bp out_valid", 16, 32'(bus16.out_valid), 32'd1);
    ra = 16'h1234;
    rb = 16'h4321;
    repeat (3) begin
      @(negedge clk);
      bus16.in_valid  = 1'b1;
      bus16.a         = ra;
      bus16.b         = rb;
      bus16.c_in      = 1'b0;
      bus16.sub       = 1'b1;
      bus16.sat       = 1'b0;
      bus16.out_ready = 1'b0;
      #3;
      check("bp in_ready", 16, 32'(bus16.in_ready), 32'd0);
      check("bp out_valid held", 16, 32'(bus16.out_valid), 32'd1);
      if (q16.size() != 0) begin
        check("bp s held", 16, 32'(bus16.s), 32'(q16[0].s));
        check("bp c_out held", 16, 32'(bus16.c_out), 32'(q16[0].co));
        check("bp overflow held", 16, 32'(bus16.overflow), 32'(q16[0].ov));
      end
    end
    rdy16 = 1'b1;
    drive16(ra, rb, 1'b0, 1'b1, 1'b0, tries);
    tick16(1);
    wait_drain16();

    // Random traffic with random downstream readiness.
    rnd_rdy = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) != 0)
        drive16(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), tries);
      else
        tick16(1);
    end
    rnd_rdy = 1'b0;
    rdy16   = 1'b1;
    tick16(1);
    wait_drain16();

    // Asynchronous reset in the middle of a stream.
    lat_check = 1'b1;
    for (int i = 0; i < 6; i++)
      drive16(16'($urandom) | 16'h0101, 16'($urandom), 1'($urandom), 1'($urandom), 1'b0, tries);
    @(negedge clk);
    bus16.in_valid = 1'b0;
    #1;
    check("pre-reset out_valid", 16, 32'(bus16.out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset out_valid", 16, 32'(bus16.out_valid), 32'd0);
    check("async reset s", 16, 32'(bus16.s), 32'd0);
    check("async reset c_out", 16, 32'(bus16.c_out), 32'd0);
    check("async reset overflow", 16, 32'(bus16.overflow), 32'd0);
    q16.delete();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post-reset in_ready", 16, 32'(bus16.in_ready), 32'd1);
    tick16(8);
    drive16(16'h0FFF, 16'h0001, 1'b0, 1'b0, 1'b0, tries);
    tick16(1);
    wait_drain16();
    lat_check = 1'b0;

    // Exhaustive 6-bit sweep on the three small instances in parallel.
    start6 = 1'b1;
    for (int k = 0; k < 40000 && !(g6[0].done && g6[1].done && g6[2].done); k++) @(negedge clk);
    check("w6 sweep finished", 6, 32'(g6[0].done && g6[1].done && g6[2].done), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
